// File: rtl/rtype_decode_stage.sv
// rtl/rtype_decode_stage.sv - R-type decode stage with ALU one-hot enables behind a 2-entry skid buffer
module rtype_decode_stage #(
   parameter int CNT_W = 16
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             flush,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [31:0]      in_instr,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [4:0]       out_rs1,
   output logic [4:0]       out_rs2,
   output logic [4:0]       out_rd,
   output logic             Radd_en,
   output logic             Rsub_en,
   output logic             Ror_en,
   output logic             Rxor_en,
   output logic             Rand_en,
   output logic             Rslt_en,
   output logic             Rsltu_en,
   output logic             Rsll_en,
   output logic             Rsrl_en,
   output logic             Rsra_en,
   output logic             out_wb_en,
   output logic             out_illegal,
   output logic [CNT_W-1:0] illegal_cnt
);

   typedef enum logic [1:0] {EMPTY, ONE, FULL} state_t;

   // ops bit order: add, sub, or, xor, and, slt, sltu, sll, srl, sra (bit 0 first)
   typedef struct packed {
      logic [4:0] rs1;
      logic [4:0] rs2;
      logic [4:0] rd;
      logic [9:0] ops;
      logic       wb;
      logic       illegal;
   } dec_t;

   state_t           state;
   dec_t             dec;
   dec_t             main_q;
   dec_t             skid_q;
   logic             ready_q;
   logic [CNT_W-1:0] cnt_q;
   logic             accept;
   logic             drain;

   // in_ready comes from a register; rst masks it so nothing is taken during reset
   assign in_ready  = ready_q && !rst;
   assign out_valid = (state != EMPTY);
   assign accept    = in_valid && in_ready && !flush;
   assign drain     = out_valid && out_ready;

   // Decode the incoming word into register addresses and a one-hot op vector
   always_comb begin
      dec     = '0;
      dec.rs1 = in_instr[19:15];
      dec.rs2 = in_instr[24:20];
      dec.rd  = in_instr[11:7];
      if (in_instr[6:0] == 7'b0110011) begin
         case ({in_instr[31:25], in_instr[14:12]})
            10'b0000000_000: dec.ops = 10'b0000000001;
            10'b0100000_000: dec.ops = 10'b0000000010;
            10'b0000000_110: dec.ops = 10'b0000000100;
            10'b0000000_100: dec.ops = 10'b0000001000;
            10'b0000000_111: dec.ops = 10'b0000010000;
            10'b0000000_010: dec.ops = 10'b0000100000;
            10'b0000000_011: dec.ops = 10'b0001000000;
            10'b0000000_001: dec.ops = 10'b0010000000;
            10'b0000000_101: dec.ops = 10'b0100000000;
            10'b0100000_101: dec.ops = 10'b1000000000;
            default:         dec.ops = 10'b0000000000;
         endcase
      end
      dec.illegal = (dec.ops == 10'b0);
      dec.wb      = !dec.illegal && (dec.rd != 5'd0);
   end

   // Skid-buffer FSM: main feeds the outputs, skid catches one word while stalled
   always_ff @(posedge clk) begin
      if (rst) begin
         state   <= EMPTY;
         main_q  <= '0;
         skid_q  <= '0;
         ready_q <= 1'b1;
      end else if (flush) begin
         state   <= EMPTY;
         ready_q <= 1'b1;
      end else begin
         case (state)
            EMPTY: begin
               if (accept) begin
                  main_q <= dec;
                  state  <= ONE;
               end
            end
            ONE: begin
               if (accept && drain) begin
                  main_q <= dec;
               end else if (accept) begin
                  skid_q  <= dec;
                  state   <= FULL;
                  ready_q <= 1'b0;
               end else if (drain) begin
                  state <= EMPTY;
               end
            end
            FULL: begin
               if (drain) begin
                  main_q  <= skid_q;
                  state   <= ONE;
                  ready_q <= 1'b1;
               end
            end
            default: begin
               state   <= EMPTY;
               ready_q <= 1'b1;
            end
         endcase
      end
   end

   // Count illegal entries as they are handed downstream, holding at all-ones
   always_ff @(posedge clk) begin
      if (rst) begin
         cnt_q <= '0;
      end else if (drain && main_q.illegal && (cnt_q != {CNT_W{1'b1}})) begin
         cnt_q <= cnt_q + CNT_W'(1);
      end
   end

   assign out_rs1     = main_q.rs1;
   assign out_rs2     = main_q.rs2;
   assign out_rd      = main_q.rd;
   assign {Rsra_en, Rsrl_en, Rsll_en, Rsltu_en, Rslt_en,
           Rand_en, Rxor_en, Ror_en, Rsub_en, Radd_en} = main_q.ops & {10{out_valid}};
   assign out_wb_en   = main_q.wb && out_valid;
   assign out_illegal = main_q.illegal && out_valid;
   assign illegal_cnt = cnt_q;

endmodule
